// File: rtl/dm_abs_cmd_seq_if.sv
// Handshake bundle between the DM register file / hart side and the abstract-command sequencer.
interface dm_abs_cmd_seq_if #(
  parameter int unsigned ABS_WORDS = 8
);
  localparam int unsigned AW = $clog2(ABS_WORDS);

  logic          dmactive;
  logic          cmd_valid;
  logic [31:0]   cmd;
  logic [2:0]    cmderr_clr;
  logic          halted;
  logic          abs_we;
  logic [AW-1:0] abs_addr;
  logic [31:0]   abs_wdata;
  logic          go;
  logic          done;
  logic          exc;
  logic          abort;
  logic          busy;
  logic [2:0]    cmderr;
  logic          postinc;
  logic          postinc_arsel;

  modport master (
    output dmactive, cmd_valid, cmd, cmderr_clr, halted, done, exc,
    input  abs_we, abs_addr, abs_wdata, go, abort, busy, cmderr, postinc, postinc_arsel
  );

  modport slave (
    input  dmactive, cmd_valid, cmd, cmderr_clr, halted, done, exc,
    output abs_we, abs_addr, abs_wdata, go, abort, busy, cmderr, postinc, postinc_arsel
  );
endinterface

// File: rtl/dm_abs_cmd_seq.sv
// Abstract-command sequencer: validates a DM COMMAND, writes the abstract program into
// the buffer, launches the halted hart and tracks busy plus a sticky cmderr.
module dm_abs_cmd_seq #(
  parameter int unsigned XLEN      = 64,
  parameter bit          HAS_FPU   = 1'b1,
  parameter int unsigned ABS_WORDS = 8,
  parameter logic [11:0] DATA_ADDR = 12'h380,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic            clk,
  input logic            rst,
  dm_abs_cmd_seq_if.slave bus
);

  localparam int unsigned AW = $clog2(ABS_WORDS);
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [2:0] ERR_NONE = 3'd0, ERR_BUSY = 3'd1, ERR_NOT_SUPPORTED = 3'd2,
                         ERR_EXCEPTION = 3'd3, ERR_HALT_RESUME = 3'd4, ERR_OTHER = 3'd7;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [6:0]  OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_LOADFP = 7'b0000111, OP_STOREFP = 7'b0100111;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7b2, CSR_DSCRATCH1 = 12'h7b3;
  localparam logic [11:0] ARG1 = DATA_ADDR + 12'(XLEN / 8);
  localparam logic [2:0]  XLEN_SZ = (XLEN == 64) ? 3'd3 : 3'd2;
  localparam logic [4:0]  X0 = 5'd0, X10 = 5'd10, X11 = 5'd11;

  typedef enum logic [2:0] {IDLE, CHECK, GEN, GO, WAIT, DONE} state_e;

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm,
                                           input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [11:0] imm,
                                            input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_csrw(input logic [11:0] csr, input logic [4:0] rs1);
    return {csr, rs1, 3'b001, X0, 7'b1110011};
  endfunction

  function automatic logic [31:0] enc_csrr(input logic [4:0] rd, input logic [11:0] csr);
    return {csr, X0, 3'b010, rd, 7'b1110011};
  endfunction

  state_e         state, state_nxt;
  logic [31:0]    cmd_q;
  logic [AW-1:0]  idx;
  logic [TW-1:0]  cnt;
  logic [2:0]     cmderr, cmderr_nxt, err_new, chk_err;
  logic           ok;
  logic           clr_ctl;
  logic           timeout_hit;
  logic           postinc_fire;
  logic [31:0]    prog [ABS_WORDS];
  logic [31:0]    term;

  logic [7:0]  cmdtype;
  logic [2:0]  size;
  logic [15:0] regno;
  logic        postinc_en, postexec, transfer, is_write, aamvirtual;
  logic        is_reg, is_mem, is_csr, is_gpr, is_fpr;

  assign clr_ctl    = rst | ~bus.dmactive;
  assign cmdtype    = cmd_q[31:24];
  assign aamvirtual = cmd_q[23];
  assign size       = cmd_q[22:20];
  assign postinc_en = cmd_q[19];
  assign postexec   = cmd_q[18];
  assign transfer   = cmd_q[17];
  assign is_write   = cmd_q[16];
  assign regno      = cmd_q[15:0];
  assign is_reg     = (cmdtype == 8'd0);
  assign is_mem     = (cmdtype == 8'd2);
  assign is_csr     = (regno[15:12] == 4'h0);
  assign is_gpr     = (regno[15:5] == 11'h080);
  assign is_fpr     = (regno[15:5] == 11'h081);
  assign timeout_hit = (cnt == TW'(TIMEOUT - 1));
  assign postinc_fire = (state == DONE) && ok && postinc_en;

  always_comb begin
    chk_err = ERR_NONE;
    if (is_reg) begin
      if (transfer && !(size == 3'd2 || (size == 3'd3 && XLEN == 64)))
        chk_err = ERR_NOT_SUPPORTED;
      else if (!(is_csr || is_gpr || (is_fpr && HAS_FPU)))
        chk_err = ERR_NOT_SUPPORTED;
    end else if (is_mem) begin
      if (aamvirtual || ((32'd8 << size) > XLEN))
        chk_err = ERR_NOT_SUPPORTED;
    end else begin
      chk_err = ERR_NOT_SUPPORTED;
    end
    if (chk_err == ERR_NONE && !bus.halted)
      chk_err = ERR_HALT_RESUME;
  end

  // Program image; slots not used by a sequence stay nop. CSR/memory paths borrow x10/x11 via dscratch.
  always_comb begin
    for (int i = 0; i < int'(ABS_WORDS); i++) prog[i] = NOP;
    term = (is_reg && postexec) ? NOP : EBREAK;
    if (is_reg) begin
      if (!transfer) begin
        prog[1] = term;
      end else if (is_gpr) begin
        prog[0] = is_write ? enc_load(size, regno[4:0], X0, DATA_ADDR, OP_LOAD)
                           : enc_store(size, regno[4:0], X0, DATA_ADDR, OP_STORE);
        prog[1] = term;
      end else if (is_fpr) begin
        prog[0] = is_write ? enc_load(size, regno[4:0], X0, DATA_ADDR, OP_LOADFP)
                           : enc_store(size, regno[4:0], X0, DATA_ADDR, OP_STOREFP);
        prog[1] = term;
      end else begin
        prog[0] = enc_csrw(CSR_DSCRATCH1, X10);
        if (is_write) begin
          prog[1] = enc_load(size, X10, X0, DATA_ADDR, OP_LOAD);
          prog[2] = enc_csrw(regno[11:0], X10);
        end else begin
          prog[1] = enc_csrr(X10, regno[11:0]);
          prog[2] = enc_store(size, X10, X0, DATA_ADDR, OP_STORE);
        end
        prog[3] = enc_csrr(X10, CSR_DSCRATCH1);
        prog[4] = term;
      end
    end else begin
      prog[0] = enc_csrw(CSR_DSCRATCH0, X10);
      prog[1] = enc_csrw(CSR_DSCRATCH1, X11);
      prog[2] = enc_load(XLEN_SZ, X10, X0, ARG1, OP_LOAD);
      if (is_write) begin
        prog[3] = enc_load(size, X11, X0, DATA_ADDR, OP_LOAD);
        prog[4] = enc_store(size, X11, X10, 12'h000, OP_STORE);
      end else begin
        prog[3] = enc_load(size, X11, X10, 12'h000, OP_LOAD);
        prog[4] = enc_store(size, X11, X0, DATA_ADDR, OP_STORE);
      end
      prog[5] = enc_csrr(X10, CSR_DSCRATCH0);
      prog[6] = enc_csrr(X11, CSR_DSCRATCH1);
      prog[7] = term;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_ctl) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.cmd_valid && cmderr == ERR_NONE) state_nxt = CHECK;
      CHECK: state_nxt = (chk_err != ERR_NONE) ? DONE : GEN;
      GEN:   if (idx == AW'(ABS_WORDS - 1)) state_nxt = GO;
      GO:    state_nxt = WAIT;
      WAIT:  if (bus.exc || bus.done || timeout_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = (state != IDLE);
    bus.abs_we        = (state == GEN);
    bus.abs_addr      = (state == GEN) ? idx : '0;
    bus.abs_wdata     = (state == GEN) ? prog[idx] : '0;
    bus.go            = (state == GO);
    bus.abort         = (state == WAIT) && timeout_hit && !bus.done && !bus.exc;
    bus.postinc       = postinc_fire;
    bus.postinc_arsel = postinc_fire && is_reg;
    bus.cmderr        = cmderr;
  end

  always_ff @(posedge clk) begin
    if (clr_ctl) begin
      idx <= '0;
      cnt <= '0;
      ok  <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          idx <= '0;
          ok  <= 1'b0;
        end
        GEN:  idx <= idx + AW'(1);
        GO:   cnt <= '0;
        WAIT: begin
          cnt <= cnt + TW'(1);
          if (bus.done && !bus.exc) ok <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cmd_valid && cmderr == ERR_NONE) cmd_q <= bus.cmd;
  end

  // First error wins unless the same-cycle clear has already emptied cmderr.
  always_comb begin
    err_new = ERR_NONE;
    case (state)
      CHECK: err_new = chk_err;
      WAIT: begin
        if (bus.exc)                      err_new = ERR_EXCEPTION;
        else if (!bus.done && timeout_hit) err_new = ERR_OTHER;
      end
      default: ;
    endcase
    if (err_new == ERR_NONE && bus.cmd_valid && state != IDLE) err_new = ERR_BUSY;
    cmderr_nxt = cmderr & ~bus.cmderr_clr;
    if (cmderr_nxt == ERR_NONE) cmderr_nxt = err_new;
  end

  always_ff @(posedge clk) begin
    if (clr_ctl) cmderr <= ERR_NONE;
    else         cmderr <= cmderr_nxt;
  end

endmodule
